// File: rtl/ctrl_pkg.sv
// Shared fetch-side types and defaults for the hazard-controlled fetch stage.
package ctrl_pkg;

    localparam int unsigned CTRL_PC_WIDTH   = 32;
    localparam int unsigned CTRL_INST_WIDTH = 32;

    localparam logic [CTRL_PC_WIDTH-1:0] CTRL_RESET_PC = '0;
    localparam logic [CTRL_PC_WIDTH-1:0] CTRL_PC_INC   = 32'd4;

    typedef struct packed {
        logic [CTRL_PC_WIDTH-1:0]   pc;
        logic [CTRL_INST_WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry holding register that catches a returning fetch while the pipe is stalled.
module if_skid_buffer
    import ctrl_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   drain,
    input  logic   clear,
    input  entry_t din,
    output logic   valid,
    output entry_t dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_if_id_stage.sv
// Fetch stage: PC register, synchronous instruction-memory request tracking and IF/ID register.
module fetch_if_id_stage
    import ctrl_pkg::*;
#(
    parameter int unsigned          PC_WIDTH   = CTRL_PC_WIDTH,
    parameter int unsigned          INST_WIDTH = CTRL_INST_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = PC_WIDTH'(CTRL_RESET_PC),
    parameter logic [PC_WIDTH-1:0]  PC_INC     = PC_WIDTH'(CTRL_PC_INC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_rd_en,
    input  logic                  stall,
    input  logic                  general_flush,
    input  logic                  select_new_pc,
    input  logic [PC_WIDTH-1:0]   new_pc,
    output logic                  inst_mem_rd_en,
    output logic [PC_WIDTH-1:0]   inst_mem_addr,
    input  logic [INST_WIDTH-1:0] inst_mem_data,
    output logic                  if_id_valid,
    output logic [PC_WIDTH-1:0]   if_id_pc,
    output logic [INST_WIDTH-1:0] if_id_inst,
    output logic                  pc_misalign
);

    typedef struct packed {
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } entry_t;

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] req_pc;
    logic                req_vld;
    logic                skid_vld;
    entry_t              skid_entry;
    entry_t              resp_entry;
    logic                kill;
    logic                issue;

    assign kill           = select_new_pc | general_flush;
    assign issue          = inst_rd_en & ~stall & ~select_new_pc;
    assign inst_mem_rd_en = issue & rst_n;
    assign inst_mem_addr  = pc_q;

    always_comb begin
        resp_entry      = '0;
        resp_entry.pc   = req_pc;
        resp_entry.inst = inst_mem_data;
    end

    // Stall blocks issue, so at most one response can be outstanding when the skid loads.
    if_skid_buffer #(
        .entry_t (entry_t)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (~kill & stall & req_vld),
        .drain (~kill & ~stall & skid_vld),
        .clear (kill),
        .din   (resp_entry),
        .valid (skid_vld),
        .dout  (skid_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            req_vld     <= 1'b0;
            req_pc      <= '0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_inst  <= '0;
            pc_misalign <= 1'b0;
        end else begin
            if (issue) begin
                pc_q   <= pc_q + PC_INC;
                req_pc <= pc_q;
            end
            req_vld <= issue & ~kill;

            if (kill) begin
                if_id_valid <= 1'b0;
                if (select_new_pc) begin
                    pc_q        <= new_pc;
                    pc_misalign <= pc_misalign | (new_pc[1:0] != 2'b00);
                end
            end else if (!stall) begin
                if (skid_vld) begin
                    if_id_valid <= 1'b1;
                    if_id_pc    <= skid_entry.pc;
                    if_id_inst  <= skid_entry.inst;
                end else begin
                    if_id_valid <= req_vld;
                    if_id_pc    <= resp_entry.pc;
                    if_id_inst  <= resp_entry.inst;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Directed table-driven bench for fetch_if_id_stage with a 1-cycle synchronous memory model.
module tb_fetch_if_id_stage;

    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    logic        clk;
    logic        rst_n;
    logic        inst_rd_en;
    logic        stall;
    logic        general_flush;
    logic        select_new_pc;
    logic [31:0] new_pc;
    logic        inst_mem_rd_en;
    logic [31:0] inst_mem_addr;
    logic [31:0] inst_mem_data;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        pc_misalign;

    int unsigned total;
    int unsigned passed;

    typedef struct packed {
        logic        en;
        logic        st;
        logic        fl;
        logic        sel;
        logic [31:0] npc;
        logic        erd;
        logic [31:0] eaddr;
        logic        evld;
        logic [31:0] epc;
        logic        emis;
    } vec_t;

    vec_t vecs [23];

    fetch_if_id_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_rd_en     (inst_rd_en),
        .stall          (stall),
        .general_flush  (general_flush),
        .select_new_pc  (select_new_pc),
        .new_pc         (new_pc),
        .inst_mem_rd_en (inst_mem_rd_en),
        .inst_mem_addr  (inst_mem_addr),
        .inst_mem_data  (inst_mem_data),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_inst     (if_id_inst),
        .pc_misalign    (pc_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Unread cycles return a poison word so wrong-path data is recognisable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inst_mem_data <= BAD;
        else
            inst_mem_data <= inst_mem_rd_en ? mem_word(inst_mem_addr) : BAD;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    endtask

    task automatic step_chk(input string tag, input logic erd, input logic [31:0] eaddr,
                            input logic evld, input logic [31:0] epc, input logic emis);
        chk({tag, "_rd"}, 32'(inst_mem_rd_en), 32'(erd));
        chk({tag, "_addr"}, inst_mem_addr, eaddr);
        chk({tag, "_vld"}, 32'(if_id_valid), 32'(evld));
        chk({tag, "_mis"}, 32'(pc_misalign), 32'(emis));
        chk({tag, "_inv"}, 32'(dut.skid_vld & dut.req_vld), 32'd0);
        if (evld) begin
            chk({tag, "_pc"}, if_id_pc, epc);
            chk({tag, "_inst"}, if_id_inst, mem_word(epc));
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        //          en st fl sel npc            rd  addr           vld pc             mis
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'h0,        1'b0,32'h0,        1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'h4,        1'b0,32'h0,        1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'h8,        1'b1,32'h0,        1'b0};
        vecs[3]  = '{1'b1,1'b1,1'b0,1'b0,32'h0,       1'b0,32'hC,        1'b1,32'h4,        1'b0};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'hC,        1'b1,32'h4,        1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'h10,       1'b1,32'h8,        1'b0};
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b1,32'h100,     1'b0,32'h14,       1'b1,32'hC,        1'b0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'h100,      1'b0,32'h0,        1'b0};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'h104,      1'b0,32'h0,        1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'h108,      1'b1,32'h100,      1'b0};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,32'h0,       1'b0,32'h10C,      1'b1,32'h104,      1'b0};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'h10C,      1'b1,32'h108,      1'b0};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'h110,      1'b0,32'h0,        1'b0};
        vecs[13] = '{1'b1,1'b1,1'b0,1'b0,32'h0,       1'b0,32'h114,      1'b1,32'h10C,      1'b0};
        vecs[14] = '{1'b0,1'b0,1'b1,1'b0,32'h0,       1'b0,32'h114,      1'b1,32'h10C,      1'b0};
        vecs[15] = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'h114,      1'b0,32'h0,        1'b0};
        vecs[16] = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'h118,      1'b0,32'h0,        1'b0};
        vecs[17] = '{1'b1,1'b0,1'b0,1'b1,32'h102,     1'b0,32'h11C,      1'b1,32'h114,      1'b0};
        vecs[18] = '{1'b1,1'b0,1'b0,1'b1,32'hFFFFFFFC,1'b0,32'h102,      1'b0,32'h0,        1'b1};
        vecs[19] = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'hFFFFFFFC, 1'b0,32'h0,        1'b1};
        vecs[20] = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'h0,        1'b0,32'h0,        1'b1};
        vecs[21] = '{1'b1,1'b0,1'b0,1'b0,32'h0,       1'b1,32'h4,        1'b1,32'hFFFFFFFC, 1'b1};
        vecs[22] = '{1'b1,1'b1,1'b0,1'b0,32'h0,       1'b0,32'h8,        1'b1,32'h0,        1'b1};

        rst_n         = 1'b0;
        inst_rd_en    = 1'b1;
        stall         = 1'b0;
        general_flush = 1'b0;
        select_new_pc = 1'b0;
        new_pc        = '0;

        @(negedge clk);
        #1;
        chk("rst_rd", 32'(inst_mem_rd_en), 32'd0);
        chk("rst_addr", inst_mem_addr, 32'h0);
        chk("rst_vld", 32'(if_id_valid), 32'd0);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_inst", if_id_inst, 32'h0);
        chk("rst_mis", 32'(pc_misalign), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            inst_rd_en    = vecs[i].en;
            stall         = vecs[i].st;
            general_flush = vecs[i].fl;
            select_new_pc = vecs[i].sel;
            new_pc        = vecs[i].npc;
            #1;
            step_chk($sformatf("v%0d", i), vecs[i].erd, vecs[i].eaddr, vecs[i].evld,
                     vecs[i].epc, vecs[i].emis);
            @(negedge clk);
        end

        // Mid-cycle asynchronous reset with the skid holding pc 4.
        chk("t6_skid_full", 32'(dut.skid_vld), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rd", 32'(inst_mem_rd_en), 32'd0);
        chk("t6_addr", inst_mem_addr, 32'h0);
        chk("t6_vld", 32'(if_id_valid), 32'd0);
        chk("t6_pc", if_id_pc, 32'h0);
        chk("t6_inst", if_id_inst, 32'h0);
        chk("t6_mis", 32'(pc_misalign), 32'd0);
        chk("t6_skid", 32'(dut.skid_vld), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        inst_rd_en = 1'b1;

        #1;
        step_chk("r0", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        step_chk("r1", 1'b1, 32'h4, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        step_chk("r2", 1'b1, 32'h8, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        step_chk("r3", 1'b1, 32'hC, 1'b1, 32'h4, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
